// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, scan FSM state type and hex 7-segment table
// Patterns are {g,f,e,d,c,b,a}; b and d are the lowercase forms.
package seg_pkg;
  localparam int SEG_W = 8;
  localparam int DIGITS = 4;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display update handshake (value, dp, upd_valid -> upd_ready)
// master drives value/dp/upd_valid and samples upd_ready; slave is the scan controller.
interface seg_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0] dp;
  logic upd_valid;
  logic upd_ready;
  modport master(output value, dp, upd_valid, input upd_ready);
  modport slave(input value, dp, upd_valid, output upd_ready);
endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to 7-segment pattern
// Ports: nib in [3:0]; pat out [6:0] = {g..a}.
module seg_hex_decode
  import seg_pkg::*;
(
  input logic [3:0] nib,
  output logic [6:0] pat
);
  always_comb pat = HEX_SEG[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan controller with frame-aligned display updates
// Ports: clk; rst (sync, active-high); segtiming (cycles per slot, 0 acts as 1);
//   blank_cycles (dark cycles at slot start); upd (slave: value, dp, upd_valid in, upd_ready out);
//   sel1..sel4, seg[7:0] = {dp, g..a}, frame_start (all registered, active-high).
// Optional: define SEG_DIM_EN to add bright[3:0], lighting SHOW only while slot_counter[3:0] <= bright.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TIMING_W = 16,
  parameter int BLANK_W = 8
) (
  input logic clk,
  input logic rst,
  input logic [TIMING_W-1:0] segtiming,
  input logic [BLANK_W-1:0] blank_cycles,
`ifdef SEG_DIM_EN
  input logic [3:0] bright,
`endif
  seg_scan_ctrl_if.slave upd,
  output logic sel1,
  output logic sel2,
  output logic sel3,
  output logic sel4,
  output logic [SEG_W-1:0] seg,
  output logic frame_start
);
  localparam int DW = $clog2(DIGITS);
  scan_state_t state;
  logic [DW-1:0] digit, n_digit;
  logic [TIMING_W-1:0] cnt, n_cnt, eff_t, n_eff_t;
  logic [BLANK_W-1:0] eff_b, n_eff_b;
  logic [15:0] shadow_v, pend_v, n_val;
  logic [3:0] shadow_dp, pend_dp, n_dp, nib;
  logic [6:0] pat;
  logic pend_full, slot_end, wrap, apply, n_show, lit;
`ifdef SEG_DIM_EN
  logic [3:0] brt, n_brt;
`endif
  assign upd.upd_ready = ~pend_full;
  // Outputs are registered, so everything below describes the cycle after the next edge.
  always_comb begin
    slot_end = state == IDLE || cnt == eff_t - 1'b1;
    wrap = slot_end && (state == IDLE || digit == DW'(DIGITS - 1));
    apply = wrap && pend_full;
    n_eff_t = slot_end ? (segtiming == '0 ? TIMING_W'(1) : segtiming) : eff_t;
    n_eff_b = slot_end ? blank_cycles : eff_b;
    n_cnt = slot_end ? '0 : cnt + 1'b1;
    n_digit = state == IDLE ? '0 : digit + DW'(slot_end);
    n_val = apply ? pend_v : shadow_v;
    n_dp = apply ? pend_dp : shadow_dp;
    nib = n_val[{n_digit, 2'b00} +: 4];
    n_show = 32'(n_cnt) >= 32'(n_eff_b);
`ifdef SEG_DIM_EN
    n_brt = slot_end ? bright : brt;
    lit = n_show && n_cnt[3:0] <= n_brt;
`else
    lit = n_show;
`endif
  end
  seg_hex_decode u_dec (.nib(nib), .pat(pat));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      digit <= '0;
      cnt <= '0;
      eff_t <= '0;
      eff_b <= '0;
      shadow_v <= '0;
      shadow_dp <= '0;
      pend_v <= '0;
      pend_dp <= '0;
      pend_full <= 1'b0;
      {sel4, sel3, sel2, sel1} <= '0;
      seg <= '0;
      frame_start <= 1'b0;
`ifdef SEG_DIM_EN
      brt <= '0;
`endif
    end else begin
      state <= n_show ? SHOW : BLANK;
      digit <= n_digit;
      cnt <= n_cnt;
      eff_t <= n_eff_t;
      eff_b <= n_eff_b;
      shadow_v <= n_val;
      shadow_dp <= n_dp;
      // A capture and a frame-boundary apply never coincide: apply needs pend_full, capture needs it clear.
      if (upd.upd_valid && !pend_full) begin
        pend_v <= upd.value;
        pend_dp <= upd.dp;
        pend_full <= 1'b1;
      end else if (apply) pend_full <= 1'b0;
      {sel4, sel3, sel2, sel1} <= lit ? 4'b0001 << n_digit : 4'b0000;
      seg <= lit ? {n_dp[n_digit], pat} : '0;
      frame_start <= wrap;
`ifdef SEG_DIM_EN
      brt <= n_brt;
`endif
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized self-checking bench against a frame-arithmetic reference model
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] segtiming;
  logic [7:0] blank_cycles;
`ifdef SEG_DIM_EN
  logic [3:0] bright = 4'hF;
`endif
  logic sel1, sel2, sel3, sel4, frame_start;
  logic [7:0] seg;
  seg_scan_ctrl_if u_if();
  seg_scan_ctrl dut (
    .clk(clk),
    .rst(rst),
    .segtiming(segtiming),
    .blank_cycles(blank_cycles),
`ifdef SEG_DIM_EN
    .bright(bright),
`endif
    .upd(u_if.slave),
    .sel1(sel1),
    .sel2(sel2),
    .sel3(sel3),
    .sel4(sel4),
    .seg(seg),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  int tests = 0;
  int fails = 0;
  int n, tt, bb;
  int brt = 15;
  logic [15:0] sh_v, pd_v;
  logic [3:0] sh_dp, pd_dp;
  bit pd_full;
  wire [13:0] got = {sel4, sel3, sel2, sel1, seg, frame_start, u_if.upd_ready};

  // Expected outputs of cycle n since the digit-0 slot began: slot = n / T, position = n % T.
  function automatic logic [13:0] expect_out();
    int k, d;
    bit lit;
    logic [3:0] s, nb;
    logic [7:0] sg;
    k = n % tt;
    d = (n / tt) % 4;
    lit = k >= bb;
`ifdef SEG_DIM_EN
    lit = lit && (k % 16) <= brt;
`endif
    nb = sh_v[d*4 +: 4];
    s = lit ? 4'(1 << d) : 4'b0;
    sg = lit ? {sh_dp[d], HEX[nb]} : 8'h00;
    return {s, sg, n % (4 * tt) == 0, !pd_full};
  endfunction

  task automatic cycle(input bit v, input logic [15:0] val, input logic [3:0] d);
    logic [13:0] e;
    bit acc;
    e = expect_out();
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL scan n=%0d T=%0d B=%0d: got %h expected %h", n, tt, bb, got, e);
    end
    u_if.upd_valid = v;
    u_if.value = val;
    u_if.dp = d;
    acc = v && !pd_full;
    if (n % (4 * tt) == 4 * tt - 1 && pd_full) begin
      sh_v = pd_v;
      sh_dp = pd_dp;
      pd_full = 0;
    end
    if (acc) begin
      pd_v = val;
      pd_dp = d;
      pd_full = 1;
    end
    @(negedge clk);
    n++;
  endtask

  task automatic idle(input int c);
    repeat (c) cycle(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic start(input int t, input int b);
    rst = 1'b1;
    u_if.upd_valid = 1'b0;
    u_if.value = 16'h0;
    u_if.dp = 4'h0;
    segtiming = 16'(t);
    blank_cycles = 8'(b);
    @(negedge clk);
    tests++;
    if (got !== 14'h0001) begin
      fails++;
      $display("FAIL reset: got %h expected %h", got, 14'h0001);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n = 0;
    tt = t < 1 ? 1 : t;
    bb = b;
    sh_v = 16'h0;
    sh_dp = 4'h0;
    pd_full = 0;
  endtask

  task automatic test_reset();
    start(4, 1);
    idle(4);
  endtask

  task automatic test_scan();
    start(4, 1);
    idle(48);
  endtask

  task automatic test_update();
    start(4, 1);
    idle(6);
    cycle(1'b1, 16'h1234, 4'b0001);
    idle(40);
  endtask

  task automatic test_back_to_back();
    int stage;
    bit acc;
    start(4, 1);
    idle(2);
    stage = 0;
    for (int i = 0; i < 60 && stage < 2; i++) begin
      acc = !pd_full;
      cycle(1'b1, stage == 0 ? 16'hAAAA : 16'hBBBB, 4'h0);
      if (acc) stage++;
    end
    idle(40);
  endtask

  task automatic test_boundaries();
    start(0, 0);
    idle(20);
    start(3, 5);
    idle(30);
  endtask

  task automatic test_reset_mid();
    start(4, 1);
    idle(3);
    cycle(1'b1, 16'hFFFF, 4'hF);
    while (n < 7) idle(1);
    start(4, 1);
    idle(40);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
`ifdef SEG_DIM_EN
      bright = 4'($urandom);
      brt = int'(bright);
`endif
      start(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
      repeat (150) cycle($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom));
    end
`ifdef SEG_DIM_EN
    bright = 4'hF;
    brt = 15;
`endif
  endtask

`ifdef SEG_DIM_EN
  task automatic test_dim();
    bright = 4'd3;
    brt = 3;
    start(32, 0);
    idle(140);
    bright = 4'hF;
    brt = 15;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_update();
    test_back_to_back();
    test_boundaries();
    test_reset_mid();
    test_random();
`ifdef SEG_DIM_EN
    test_dim();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the board's 4-digit common-select 7-segment display. It holds a shadow copy of four hex digits plus decimal points, and sequences digit selects with a programmable slot length and anti-ghosting blank time. It accepts new display values through a valid/ready handshake and applies them only at frame boundaries. It sits between the counter/datapath logic and the top-level pad inverters; all outputs are active-high, and the top level inverts them.

Parameters:
TIMING_W, 16, width of the segtiming input and the slot counter
BLANK_W, 8, width of the blank_cycles input

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
segtiming  in  TIMING_W  clk cycles per digit slot; 0 is treated as 1
blank_cycles  in  BLANK_W  dark cycles at the start of each slot
value  in  16  four hex nibbles; [3:0] drives digit 0 (sel1), [15:12] drives digit 3 (sel4)
dp  in  4  decimal point per digit; bit n belongs to digit n
upd_valid  in  1  update request
upd_ready  out  1  update accepted when upd_valid & upd_ready
sel1  out  1  digit 0 select
sel2  out  1  digit 1 select
sel3  out  1  digit 2 select
sel4  out  1  digit 3 select
seg  out  8  segments: [6:0] = a..g, [7] = dp
frame_start  out  1  one-cycle pulse at the first cycle of each digit-0 slot

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs, including mid-slot and mid-handshake):
  - sel1..sel4 = 0, seg = 0, frame_start = 0, upd_ready = 1.
  - Shadow and pending registers = 0; pending_full = 0.
  - FSM = IDLE; digit index = 0; slot counter = 0.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE -> BLANK unconditionally on the first cycle after rst falls. That cycle starts the digit-0 slot, and frame_start = 1.
- Slot start:
  - Latch eff_timing = max(segtiming, 1) and eff_blank = blank_cycles. Changing either input mid-slot has no effect until the next slot.
  - Slot counter runs 0 .. eff_timing-1.
- BLANK (slot counter < eff_blank): all sel = 0, seg = 0.
- SHOW: exactly one sel is high, selected by the digit index. seg = decode(shadow nibble) | (shadow dp << 7).
- Transitions:
  - BLANK -> SHOW when the counter reaches eff_blank.
  - At counter = eff_timing-1, the slot ends. Digit index increments mod 4, wrapping 3 -> 0. The next slot begins in BLANK, or directly in SHOW if eff_blank = 0.
  - If eff_blank >= eff_timing, the digit stays dark for its whole slot, but scanning still advances at the same rate.
- Output registration: sel and seg are registered; no combinational path from any input to any output.
- Frame period = 4 * eff_timing cycles.
- Decode: 0-9 and A-F in standard hex 7-segment form (b, d lowercase); digit 8 = 7'h7F.
- Handshake:
  - upd_ready = ~pending_full.
  - On valid & ready, {value, dp} is captured into pending and pending_full is set. upd_valid while ready is low is ignored (not queued).
  - Frame boundary = cycle where the digit index wraps 3 -> 0. At the boundary, if pending_full, pending is copied to shadow and pending_full clears. upd_ready returns to 1 the following cycle.
  - If valid & ready occurs in the boundary cycle, the update is captured into pending and applied at the next boundary. A frame never shows a mix of old and new digits.

Optional Feature:
SEG_DIM_EN:
- Defined:
  - Adds input bright [3:0] (latched at slot start).
  - During SHOW, sel and seg are driven only when slot_counter[3:0] <= bright; otherwise they are 0.
  - bright = 4'hF is full on; bright = 0 gives 1/16 duty.
- Undefined: the port is absent, and SHOW always drives the outputs.

Decomposition:
- Package seg_pkg:
  - SEG_W = 8, DIGITS = 4.
  - FSM state enum scan_state_t {IDLE, BLANK, SHOW}.
  - 16-entry constant array of 7-bit hex segment patterns.
- Sub-module: seg_hex_decode (combinational nibble -> 7-bit pattern, using the seg_pkg table). Instantiated once on the currently selected shadow nibble.

Test Plan:
- Reset release, segtiming = 4, blank_cycles = 1, value = 16'h0000 -> frame_start pulses every 16 cycles; sel1..sel4 each high 3 cycles per slot, in order 1,2,3,4; seg = 8'h3F while lit; all 0 during the blank cycle.
- With 16'h0000 displayed, update value = 16'h1234, dp = 4'b0001 mid-frame -> upd_ready drops the next cycle. Display unchanged until the wrap. Next frame: digit0 seg = 8'hE6 (4 + dp), digit1 8'h4F, digit2 8'h5B, digit3 8'h06. upd_ready = 1 one cycle after the wrap.
- upd_valid asserted for two back-to-back values 16'hAAAA then 16'hBBBB, upd_valid held continuously -> AAAA shown in the next frame; BBBB is accepted after the ready drop and shown one frame later; no frame shows a mix.
- segtiming = 0, blank_cycles = 0 -> one-cycle slots, and sel rotates every cycle. Separately, segtiming = 3, blank_cycles = 5 -> all outputs permanently 0, and frame_start still pulses every 12 cycles.
- rst asserted mid-SHOW with a pending update -> next cycle: all outputs 0, upd_ready = 1, shadow = 0; after release the digit-0 slot restarts and the old pending value is never displayed.
- With SEG_DIM_EN defined: bright = 3, segtiming = 32, blank_cycles = 0 -> within each slot, outputs are lit on counter values 0-3, 16-19 and dark otherwise.
